sdram_wb_arbiter: RTL

//  Two-master Wishbone arbiter directly upstream of the SDRAM Wishbone controller.
//  M0 = video fetch: high priority. M1 = CPU/DMA: low priority, with anti-starvation.
//  One granted master at a time is routed to the single slave port that feeds the controller.

---
 rtl/sdram_wb_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller. M0 (video) has priority, and M1
// (CPU/DMA) gets starvation relief. The stall timeout is built in only when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_wb_arbiter #(
  parameter int unsigned AW          = 24,
  parameter int unsigned DW          = 16,
  parameter int unsigned SW          = 2,
  parameter int unsigned STARVE_MAX  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536)
  begin : g_bad_params
    $error("sdram_wb_arbiter: STARVE_MAX or TIMEOUT_CYC out of range");
  end

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       m0_req, m1_req, starved, gnt0, gnt1, tmo;

  assign m0_req  = m0_cyc_i & m0_stb_i;
  assign m1_req  = m1_cyc_i & m1_stb_i;
  assign starved = (starve_q == StarveMax);
  assign gnt0    = (state_q == StGnt0);
  assign gnt1    = (state_q == StGnt1);
  assign grant_o = {gnt1, gnt0};

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam logic [15:0] StallLast = 16'(TIMEOUT_CYC - 1);

  logic [15:0] stall_q, stall_d;
  logic        timeout_q, timeout_d;
  logic        sel_stb;

  assign sel_stb   = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);
  assign tmo       = sel_stb & ~s_ack_i & (stall_q == StallLast);
  assign timeout_o = timeout_q;

  always_comb begin
    timeout_d = timeout_q | tmo;
    stall_d   = stall_q;
    if (state_d != state_q || s_ack_i) begin
      stall_d = '0;
    end else if (sel_stb) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign tmo       = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && (!m1_req || !starved)) begin
          state_d = StGnt0;
          if (m1_req && !starved) starve_d = starve_q + 8'd1;
        end else if (m1_req) begin
          state_d  = StGnt1;
          starve_d = '0;
        end
      end
      StGnt0:  if (!m0_cyc_i || tmo) state_d = StIdle;
      StGnt1:  if (!m1_cyc_i || tmo) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Slave strobes follow the granted master combinationally, so an abort drops s_cyc_o at once.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      StGnt0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      StGnt1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
    // A timed-out beat is terminated toward the master with a poison word.
    if (tmo) begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = gnt0;
      m1_ack_o = gnt1;
      m0_dat_o = gnt0 ? DW'(16'hDEAD) : '0;
      m1_dat_o = gnt1 ? DW'(16'hDEAD) : '0;
    end
  end

endmodule
